hazard_sb: RTL and testbench
============================

HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 Parameter REG_BITS, 5, width of register specifiers; the scoreboard SHALL hold 2**REG_BITS entries.
REQ-002 Parameter MUL_LAT, 4, multiplier result latency in cycles; the legal range SHALL be 1..15.
REQ-003 Parameter CNT_BITS, $clog2(MUL_LAT+1), width of each per-register countdown.
REQ-004 The block SHALL use one clock, clk, and a synchronous, active-high reset, reset.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
clk  in  1  clock
reset  in  1  synchronous active-high reset
rs1_D_in, rs2_D_in, rd_D_in  in  REG_BITS  source and destination registers in Decode
reg_write_D_in, is_mul_D_in  in  1  Decode instruction writes rd / is a multiply
rs1_A_in, rs2_A_in, rd_A_in  in  REG_BITS  source and destination registers in ALU stage
result_src_A_in  in  result_src_e  ALU-stage result source; FROM_CACHE marks a load
rd_C_in, rd_WB_in  in  REG_BITS  destination registers in Cache and Writeback
reg_write_C_in, reg_write_WB_in  in  1  write enables for C and WB
pc_src_in  in  pc_src_e  FROM_A means a taken branch or jump
dcache_busy_in, icache_busy_in  in  1  cache miss in progress
fwd_src1_out, fwd_src2_out  out  fwd_src_e  ALU operand forward select (NONE/FROM_C/FROM_WB)
stall_F_out, stall_D_out, stall_A_out, stall_C_out  out  1  stage holds
flush_D_out, flush_A_out, flush_WB_out  out  1  stage bubbles
sb_busy_out  out  1  any scoreboard entry is nonzero
sb_count_out  out  REG_BITS+1  number of nonzero entries

Function
REQ-006 fwd_src1_out SHALL be FROM_C if rs1_A_in==rd_C_in, reg_write_C_in is high and rs1_A_in!=0; otherwise FROM_WB if rs1_A_in==rd_WB_in, reg_write_WB_in is high and rs1_A_in!=0; otherwise NONE. C SHALL take priority over WB.
REQ-007 fwd_src2_out SHALL follow REQ-006 using rs2_A_in.
REQ-008 load_stall SHALL be high when result_src_A_in==FROM_CACHE, rd_A_in!=0, and rd_A_in equals rs1_D_in or rs2_D_in.
REQ-009 sb_stall SHALL be high when the entry for rs1_D_in, rs2_D_in, or rd_D_in (the last only if reg_write_D_in is high) is nonzero; register 0 SHALL never stall.
REQ-010 pc_taken SHALL be defined as pc_src_in==FROM_A.
REQ-011 stall_F_out SHALL equal load_stall | sb_stall | dcache_busy_in | icache_busy_in.
REQ-012 stall_D_out SHALL equal load_stall | sb_stall | dcache_busy_in.
REQ-013 stall_A_out and stall_C_out SHALL each equal dcache_busy_in; flush_WB_out SHALL equal dcache_busy_in.
REQ-014 flush_D_out SHALL equal pc_taken | icache_busy_in.
REQ-015 flush_A_out SHALL equal load_stall | sb_stall | pc_taken.
REQ-016 issue SHALL be high when is_mul_D_in, reg_write_D_in and rd_D_in!=0 are all high, and stall_D_out, flush_A_out and flush_D_out are all low.
REQ-017 On a clock edge with issue high, entry[rd_D_in] SHALL be loaded with MUL_LAT.
REQ-018 On every clock edge with dcache_busy_in low, every other nonzero entry SHALL decrement by 1; all entries SHALL hold while dcache_busy_in is high.
REQ-019 Entries SHALL saturate at 0 and never wrap.
REQ-020 An issue to an entry that is already nonzero SHALL be impossible, because REQ-009 covers WAW.
REQ-021 When a multiply issues at edge t, a dependent instruction in Decode SHALL stall for exactly MUL_LAT cycles of non-busy clock edges, then proceed.
REQ-022 sb_busy_out and sb_count_out SHALL be derived combinationally from the registered entries.
REQ-023 All outputs except sb_busy_out and sb_count_out SHALL be combinational from the inputs and the current entries.

Reset
REQ-024 While reset is high at a clock edge, all entries SHALL clear to 0, including entries for multiplies in flight; issue SHALL be ignored on that edge.
REQ-025 After reset, sb_busy_out SHALL be 0, sb_count_out SHALL be 0, and no sb_stall SHALL occur.

Verification
REQ-026 MUL_LAT=4; issue mul rd=5, then Decode rs1=5 -> stall_D_out high for 4 cycles, low on the 5th; sb_count_out goes 1 then 0.
REQ-027 Load in A with rd_A=7 and rs2_D=7 -> stall_F, stall_D and flush_A high for 1 cycle; next cycle fwd_src2_out=FROM_WB when the load is in WB.
REQ-028 rd_C=rd_WB=3 both writing, rs1_A=3 -> FROM_C; rs1_A=0 -> NONE.
REQ-029 Mul pending with counter 2 and dcache_busy_in held for 3 cycles -> counter stays 2 and stall_A/C/flush_WB are high; it then completes 2 cycles after busy drops.
REQ-030 Mul in Decode with pc_taken high -> no issue and the entry stays 0; a second mul to the same rd -> WAW stall for MUL_LAT cycles.
REQ-031 Assert reset while 3 entries are pending -> the next cycle has sb_count_out=0 and no stalls.

Source files
------------

// File: rtl/hazard_sb.sv
// Hazard unit with a multiply scoreboard: forwarding selects, load-use and pending-multiply stalls, flushes.
// Outputs are combinational from the inputs and the per-register countdowns; only the countdowns are registered.
package hazard_sb_pkg;
  typedef enum logic [1:0] {RS_ALU = 2'd0, FROM_CACHE = 2'd1, RS_PC4 = 2'd2} result_src_e;
  typedef enum logic       {PC_PLUS4 = 1'b0, FROM_A = 1'b1} pc_src_e;
  typedef enum logic [1:0] {NONE = 2'd0, FROM_C = 2'd1, FROM_WB = 2'd2} fwd_src_e;
endpackage

module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int MUL_LAT  = 4,
  parameter int CNT_BITS = $clog2(MUL_LAT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] rs1_D_in,
  input  logic [REG_BITS-1:0] rs2_D_in,
  input  logic [REG_BITS-1:0] rd_D_in,
  input  logic                reg_write_D_in,
  input  logic                is_mul_D_in,
  input  logic [REG_BITS-1:0] rs1_A_in,
  input  logic [REG_BITS-1:0] rs2_A_in,
  input  logic [REG_BITS-1:0] rd_A_in,
  input  logic [1:0]          result_src_A_in,
  input  logic [REG_BITS-1:0] rd_C_in,
  input  logic [REG_BITS-1:0] rd_WB_in,
  input  logic                reg_write_C_in,
  input  logic                reg_write_WB_in,
  input  logic                pc_src_in,
  input  logic                dcache_busy_in,
  input  logic                icache_busy_in,
  output logic [1:0]          fwd_src1_out,
  output logic [1:0]          fwd_src2_out,
  output logic                stall_F_out,
  output logic                stall_D_out,
  output logic                stall_A_out,
  output logic                stall_C_out,
  output logic                flush_D_out,
  output logic                flush_A_out,
  output logic                flush_WB_out,
  output logic                sb_busy_out,
  output logic [REG_BITS:0]   sb_count_out
);

  localparam int NREGS = 1 << REG_BITS;
  localparam logic [CNT_BITS-1:0] MUL_CNT = CNT_BITS'(MUL_LAT);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_lat_chk
    $error("hazard_sb: MUL_LAT must be within 1..15");
  end

  logic [CNT_BITS-1:0] cnt_q [NREGS];
  logic [CNT_BITS-1:0] cnt_d [NREGS];

  logic load_stall;
  logic sb_stall;
  logic pc_taken;
  logic issue;

  function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] rs,
                                         input logic [REG_BITS-1:0] rd_c,
                                         input logic                we_c,
                                         input logic [REG_BITS-1:0] rd_wb,
                                         input logic                we_wb);
    logic [1:0] sel;
    sel = NONE;
    if (rs != '0) begin
      if (we_c && rs == rd_c)        sel = FROM_C;
      else if (we_wb && rs == rd_wb) sel = FROM_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_src1_out = fwd_sel(rs1_A_in, rd_C_in, reg_write_C_in, rd_WB_in, reg_write_WB_in);
    fwd_src2_out = fwd_sel(rs2_A_in, rd_C_in, reg_write_C_in, rd_WB_in, reg_write_WB_in);

    load_stall = (result_src_A_in == FROM_CACHE) && (rd_A_in != '0) &&
                 ((rd_A_in == rs1_D_in) || (rd_A_in == rs2_D_in));

    // rd is checked only for writers: a pending multiply to the same rd is a WAW hazard
    sb_stall = ((rs1_D_in != '0) && (cnt_q[rs1_D_in] != '0)) ||
               ((rs2_D_in != '0) && (cnt_q[rs2_D_in] != '0)) ||
               (reg_write_D_in && (rd_D_in != '0) && (cnt_q[rd_D_in] != '0));

    pc_taken = (pc_src_in == FROM_A);

    stall_F_out  = load_stall | sb_stall | dcache_busy_in | icache_busy_in;
    stall_D_out  = load_stall | sb_stall | dcache_busy_in;
    stall_A_out  = dcache_busy_in;
    stall_C_out  = dcache_busy_in;
    flush_WB_out = dcache_busy_in;
    flush_D_out  = pc_taken | icache_busy_in;
    flush_A_out  = load_stall | sb_stall | pc_taken;

    issue = is_mul_D_in && reg_write_D_in && (rd_D_in != '0) &&
            !stall_D_out && !flush_A_out && !flush_D_out;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!dcache_busy_in && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_BITS'(1);
      if (issue && rd_D_in == REG_BITS'(i))  cnt_d[i] = MUL_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    sb_count_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      sb_count_out = sb_count_out + {{REG_BITS{1'b0}}, (cnt_q[i] != '0)};
    end
    sb_busy_out = (sb_count_out != '0);
  end

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_hazard_sb;
  import hazard_sb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_D, rs2_D, rd_D, rs1_A, rs2_A, rd_A, rd_C, rd_WB;
  logic       reg_write_D, is_mul_D, reg_write_C, reg_write_WB;
  logic [1:0] result_src_A;
  logic       pc_src, dcache_busy, icache_busy;
  logic [1:0] fwd1, fwd2;
  logic       stall_F, stall_D, stall_A, stall_C, flush_D, flush_A, flush_WB, sb_busy;
  logic [5:0] sb_count;

  typedef struct packed {
    logic [1:0] f1;
    logic [1:0] f2;
    logic       sf, sd, sa, sc, fd, fa, fwb, busy;
    logic [5:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sb #(.REG_BITS(5), .MUL_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .rs1_D_in(rs1_D), .rs2_D_in(rs2_D), .rd_D_in(rd_D),
    .reg_write_D_in(reg_write_D), .is_mul_D_in(is_mul_D),
    .rs1_A_in(rs1_A), .rs2_A_in(rs2_A), .rd_A_in(rd_A),
    .result_src_A_in(result_src_A),
    .rd_C_in(rd_C), .rd_WB_in(rd_WB),
    .reg_write_C_in(reg_write_C), .reg_write_WB_in(reg_write_WB),
    .pc_src_in(pc_src), .dcache_busy_in(dcache_busy), .icache_busy_in(icache_busy),
    .fwd_src1_out(fwd1), .fwd_src2_out(fwd2),
    .stall_F_out(stall_F), .stall_D_out(stall_D), .stall_A_out(stall_A), .stall_C_out(stall_C),
    .flush_D_out(flush_D), .flush_A_out(flush_A), .flush_WB_out(flush_WB),
    .sb_busy_out(sb_busy), .sb_count_out(sb_count)
  );

  function automatic exp_t mk(input logic [1:0] f1, input logic [1:0] f2,
                              input logic sf, input logic sd, input logic sa, input logic sc,
                              input logic fd, input logic fa, input logic fwb,
                              input logic [5:0] cnt);
    exp_t e;
    e.f1 = f1; e.f2 = f2;
    e.sf = sf; e.sd = sd; e.sa = sa; e.sc = sc;
    e.fd = fd; e.fa = fa; e.fwb = fwb;
    e.busy = (cnt != 6'd0);
    e.cnt = cnt;
    return e;
  endfunction

  task automatic clear();
    rs1_D = '0; rs2_D = '0; rd_D = '0; reg_write_D = 1'b0; is_mul_D = 1'b0;
    rs1_A = '0; rs2_A = '0; rd_A = '0; result_src_A = RS_ALU;
    rd_C = '0; rd_WB = '0; reg_write_C = 1'b0; reg_write_WB = 1'b0;
    pc_src = PC_PLUS4; dcache_busy = 1'b0; icache_busy = 1'b0;
  endtask

  task automatic step(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic mul(input logic [4:0] rd);
    clear();
    is_mul_D = 1'b1; reg_write_D = 1'b1; rd_D = rd;
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.f1 = fwd1; a.f2 = fwd2;
      a.sf = stall_F; a.sd = stall_D; a.sa = stall_A; a.sc = stall_C;
      a.fd = flush_D; a.fa = flush_A; a.fwb = flush_WB;
      a.busy = sb_busy; a.cnt = sb_count;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got f1=%0d f2=%0d sF%b sD%b sA%b sC%b fD%b fA%b fWB%b busy%b cnt=%0d, expected f1=%0d f2=%0d sF%b sD%b sA%b sC%b fD%b fA%b fWB%b busy%b cnt=%0d",
                 nm, a.f1, a.f2, a.sf, a.sd, a.sa, a.sc, a.fd, a.fa, a.fwb, a.busy, a.cnt,
                 e.f1, e.f2, e.sf, e.sd, e.sa, e.sc, e.fd, e.fa, e.fwb, e.busy, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    z = mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd0);
    clear();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step("reset_state", z);

    // Multiply RAW: four stalled cycles, released on the fifth
    mul(5'd5);
    step("mul_issue", z);
    clear(); rs1_D = 5'd5;
    for (int i = 0; i < 4; i++) step("mul_raw_stall", mk(NONE, NONE, 1, 1, 0, 0, 0, 1, 0, 6'd1));
    step("mul_raw_release", z);

    // Load-use, then forwarding from WB
    clear(); result_src_A = FROM_CACHE; rd_A = 5'd7; rs2_D = 5'd7;
    step("load_use_stall", mk(NONE, NONE, 1, 1, 0, 0, 0, 1, 0, 6'd0));
    clear(); rs2_A = 5'd7; rd_WB = 5'd7; reg_write_WB = 1'b1;
    step("load_fwd_wb", mk(NONE, FROM_WB, 0, 0, 0, 0, 0, 0, 0, 6'd0));
    clear(); result_src_A = FROM_CACHE; rd_A = 5'd7; rs1_D = 5'd8; rs2_D = 5'd6;
    step("load_no_dep", z);
    clear(); result_src_A = FROM_CACHE; rd_A = 5'd0; rs1_D = 5'd0;
    step("load_x0", z);

    // Forwarding priority
    clear(); rd_C = 5'd3; rd_WB = 5'd3; reg_write_C = 1'b1; reg_write_WB = 1'b1;
    rs1_A = 5'd3; rs2_A = 5'd3;
    step("fwd_c_priority", mk(FROM_C, FROM_C, 0, 0, 0, 0, 0, 0, 0, 6'd0));
    rs1_A = 5'd0;
    step("fwd_x0_none", mk(NONE, FROM_C, 0, 0, 0, 0, 0, 0, 0, 6'd0));
    rs1_A = 5'd3; reg_write_C = 1'b0;
    step("fwd_wb_only", mk(FROM_WB, FROM_WB, 0, 0, 0, 0, 0, 0, 0, 6'd0));
    clear(); rd_C = 5'd0; reg_write_C = 1'b1; rs1_A = 5'd0;
    step("fwd_rd0", z);

    // Cache misses and redirect
    clear(); icache_busy = 1'b1;
    step("icache_busy", mk(NONE, NONE, 1, 0, 0, 0, 1, 0, 0, 6'd0));
    clear(); pc_src = FROM_A;
    step("pc_taken", mk(NONE, NONE, 0, 0, 0, 0, 1, 1, 0, 6'd0));

    // Countdown freezes while dcache is busy
    mul(5'd9);
    step("mul9_issue", z);
    clear();
    step("mul9_pending4", mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd1));
    step("mul9_pending3", mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd1));
    dcache_busy = 1'b1;
    for (int i = 0; i < 3; i++) step("dcache_hold", mk(NONE, NONE, 1, 1, 1, 1, 0, 0, 1, 6'd1));
    clear(); rs1_D = 5'd9;
    step("mul9_after_busy2", mk(NONE, NONE, 1, 1, 0, 0, 0, 1, 0, 6'd1));
    step("mul9_after_busy1", mk(NONE, NONE, 1, 1, 0, 0, 0, 1, 0, 6'd1));
    step("mul9_done", z);

    // Redirected multiply must not issue; then WAW on a repeat multiply
    mul(5'd6); pc_src = FROM_A;
    step("mul_flushed", mk(NONE, NONE, 0, 0, 0, 0, 1, 1, 0, 6'd0));
    mul(5'd6);
    step("mul6_issue", z);
    for (int i = 0; i < 4; i++) step("waw_stall", mk(NONE, NONE, 1, 1, 0, 0, 0, 1, 0, 6'd1));
    step("waw_issue", z);
    clear();
    step("waw_pending", mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd1));

    // Reset with several multiplies in flight
    mul(5'd1);
    step("pend_r1", mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd1));
    mul(5'd2);
    step("pend_r2", mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd2));
    mul(5'd3);
    step("pend_r3", mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd3));
    mul(5'd4); reset = 1'b1;
    step("reset_cycle", mk(NONE, NONE, 0, 0, 0, 0, 0, 0, 0, 6'd3));
    reset = 1'b0;
    clear(); rs1_D = 5'd1; rs2_D = 5'd2; rd_D = 5'd3; reg_write_D = 1'b1;
    step("after_reset", z);
    clear(); rs1_D = 5'd4;
    step("reset_ignored_issue", z);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
